// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// MDU results are bypassed or buffered, with a pending-write scoreboard and starvation stall.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_reg_write_w,
  input  logic [4:0]    pipe_rd_w,
  input  logic [31:0]   pipe_result_w,
  input  logic          mdu_issue,
  input  logic [4:0]    mdu_issue_rd,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_rd,
  input  logic [31:0]   mdu_result,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic          rf_src,
  output logic [31:0]   pending_mask,
  output logic [CW-1:0] buf_count,
  output logic          stall_req
);

  // MDU handshake: a result moves on the rising edge where mdu_valid and
  // mdu_ready are both high; the MDU holds rd/result stable until then, and
  // mdu_ready depends only on occupancy (no pop-through when full).

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pending;
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];

  logic pipe_grant, head_grant, bypass_grant, xfer, push, pop;
  logic [31:0] set_mask, clr_mask;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  assign pipe_grant   = pipe_reg_write_w && (pipe_rd_w != 5'd0);
  assign head_grant   = !pipe_grant && (count != '0);
  assign mdu_ready    = !reset && (count < CW'(DEPTH));
  assign xfer         = mdu_valid && mdu_ready;
  assign bypass_grant = !pipe_grant && (count == '0) && xfer;
  assign push         = xfer && !bypass_grant;
  assign pop          = head_grant;

  assign buf_count    = count;
  assign pending_mask = pending;
  assign stall_req    = !reset && (starve_cnt >= SW'(STARVE_LIMIT));

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    rf_src   = 1'b0;
    if (pipe_grant) begin
      rf_we    = 1'b1;
      rf_waddr = pipe_rd_w;
      rf_wdata = pipe_result_w;
    end else if (head_grant) begin
      rf_we    = (fifo_rd[rd_ptr] != 5'd0);
      rf_waddr = fifo_rd[rd_ptr];
      rf_wdata = fifo_data[rd_ptr];
      rf_src   = 1'b1;
    end else if (bypass_grant) begin
      rf_we    = (mdu_rd != 5'd0);
      rf_waddr = mdu_rd;
      rf_wdata = mdu_result;
      rf_src   = 1'b1;
    end
    if (reset) rf_we = 1'b0;
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (mdu_issue && (mdu_issue_rd != 5'd0)) set_mask = 32'd1 << mdu_issue_rd;
    if (head_grant)        clr_mask = 32'd1 << fifo_rd[rd_ptr];
    else if (bypass_grant) clr_mask = 32'd1 << mdu_rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set is applied after clear so a same-cycle reissue keeps the bit.
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
      if ((count == '0) || head_grant)
        starve_cnt <= '0;
      else if (pipe_grant && (starve_cnt < SW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mdu_rd;
      fifo_data[wr_ptr] <= mdu_result;
    end
  end

endmodule
